// File: rtl/gpu_apb_master.sv
// rtl/gpu_apb_master.sv - command FIFO feeding a write-only APB master
module gpu_apb_master #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] CMD_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        cmd_valid_i,
    input  logic [3:0]  cmd_opcode_i,
    input  logic [24:0] cmd_params_i,
    output logic        cmd_ready_o,
    output logic [31:0] pAddr_o,
    output logic [31:0] pDataWrite_o,
    output logic        pSel_o,
    output logic        pEnable_o,
    output logic        pWrite_o,
    output logic        busy_o,
    output logic [15:0] issued_cnt_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    // FIFO entries are stored already packed as the APB write word
    logic [31:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [31:0]      r_hold;
    logic [15:0]      r_issued;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_active;

    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_push   = cmd_valid_i && !w_full;
    // A new entry is taken whenever the bus is free to start another SETUP
    assign w_pop    = !w_empty && ((r_state == S_IDLE) || (r_state == S_ACCESS));
    assign w_active = (r_state != S_IDLE);

    // Storage array needs no reset; only pointers and count define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {cmd_opcode_i, 3'b000, cmd_params_i};
        end
    end

    // Pointer and occupancy bookkeeping; power-of-two depth wraps naturally
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Next-state decode for the IDLE/SETUP/ACCESS sequence
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   w_state_nxt = w_empty ? S_IDLE : S_SETUP;
            S_SETUP:  w_state_nxt = S_ACCESS;
            S_ACCESS: w_state_nxt = w_empty ? S_IDLE : S_SETUP;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // State, hold word and completed-transfer counter
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= S_IDLE;
            r_hold   <= '0;
            r_issued <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_hold <= r_mem[r_rptr];
            end
            if (r_state == S_ACCESS) begin
                r_issued <= r_issued + 16'd1;
            end
        end
    end

    assign cmd_ready_o  = !w_full;
    assign pSel_o       = w_active;
    assign pWrite_o     = w_active;
    assign pEnable_o    = (r_state == S_ACCESS);
    assign pAddr_o      = w_active ? CMD_ADDR : 32'h0;
    assign pDataWrite_o = w_active ? r_hold : 32'h0;
    assign busy_o       = w_active || !w_empty;
    assign issued_cnt_o = r_issued;

endmodule

// File: tb/tb_gpu_apb_master.sv
// tb/tb_gpu_apb_master.sv - directed self-checking bench for gpu_apb_master
module tb_gpu_apb_master;

    localparam logic [31:0] ADDR = 32'hA000_0040;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        cmd_valid_i;
    logic [3:0]  cmd_opcode_i;
    logic [24:0] cmd_params_i;
    logic        cmd_ready_o;
    logic [31:0] pAddr_o;
    logic [31:0] pDataWrite_o;
    logic        pSel_o;
    logic        pEnable_o;
    logic        pWrite_o;
    logic        busy_o;
    logic [15:0] issued_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    gpu_apb_master #(.FIFO_DEPTH(4), .CMD_ADDR(ADDR)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_opcode_i (cmd_opcode_i),
        .cmd_params_i (cmd_params_i),
        .cmd_ready_o  (cmd_ready_o),
        .pAddr_o      (pAddr_o),
        .pDataWrite_o (pDataWrite_o),
        .pSel_o       (pSel_o),
        .pEnable_o    (pEnable_o),
        .pWrite_o     (pWrite_o),
        .busy_o       (busy_o),
        .issued_cnt_o (issued_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_apb(input string tag, input logic sel, input logic en, input logic [31:0] data);
        chk({tag, ".sel"},  {31'b0, pSel_o},    {31'b0, sel});
        chk({tag, ".en"},   {31'b0, pEnable_o}, {31'b0, en});
        chk({tag, ".wr"},   {31'b0, pWrite_o},  {31'b0, sel});
        chk({tag, ".addr"}, pAddr_o,            sel ? ADDR : 32'h0);
        chk({tag, ".data"}, pDataWrite_o,       sel ? data : 32'h0);
    endtask

    function automatic logic [31:0] word(input int seed, input int n);
        logic [3:0]  op;
        logic [24:0] pr;
        op = 4'(seed + n);
        pr = 25'(32'h0155_0000 + n * 32'h111 + seed);
        return {op, 3'b000, pr};
    endfunction

    task automatic drive(input logic v, input logic [31:0] w);
        cmd_valid_i  = v;
        cmd_opcode_i = w[31:28];
        cmd_params_i = w[24:0];
    endtask

    // Offer v commands on consecutive cycles from IDLE; t of them are issued
    // back to back. full_at is the step where the FIFO is expected full.
    task automatic run_stream(input string tag, input int seed, input int v, input int t, input int full_at);
        for (int n = 0; n <= 2 * t + 2; n++) begin
            if (n >= 2 && n < 2 * t + 2)
                chk_apb($sformatf("%s[%0d]", tag, n), 1'b1, 1'((n - 2) % 2), word(seed, (n - 2) / 2));
            else
                chk_apb($sformatf("%s[%0d]", tag, n), 1'b0, 1'b0, 32'h0);
            chk($sformatf("%s.ready[%0d]", tag, n), {31'b0, cmd_ready_o}, (n == full_at) ? 32'd0 : 32'd1);
            if (n < v) drive(1'b1, word(seed, n));
            else       drive(1'b0, 32'h0);
            @(negedge clk);
        end
    endtask

    initial begin
        n_rst = 1'b0;
        drive(1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk_apb("reset", 1'b0, 1'b0, 32'h0);
        chk("reset.busy",  {31'b0, busy_o},      32'd0);
        chk("reset.ready", {31'b0, cmd_ready_o}, 32'd1);
        chk("reset.cnt",   {16'b0, issued_cnt_o}, 32'd0);
        n_rst = 1'b1;
        @(negedge clk);
        chk_apb("post_reset", 1'b0, 1'b0, 32'h0);

        // Single command: opcode 3, params 0ABCDE
        cmd_valid_i  = 1'b1;
        cmd_opcode_i = 4'h3;
        cmd_params_i = 25'h0ABCDE;
        @(negedge clk);
        drive(1'b0, 32'h0);
        chk_apb("single.queued", 1'b0, 1'b0, 32'h0);
        chk("single.busy", {31'b0, busy_o}, 32'd1);
        @(negedge clk);
        chk_apb("single.setup", 1'b1, 1'b0, 32'h300ABCDE);
        @(negedge clk);
        chk_apb("single.access", 1'b1, 1'b1, 32'h300ABCDE);
        @(negedge clk);
        chk_apb("single.idle", 1'b0, 1'b0, 32'h0);
        chk("single.cnt",  {16'b0, issued_cnt_o}, 32'd1);
        chk("single.busy_done", {31'b0, busy_o}, 32'd0);

        // Burst of four
        run_stream("burst", 1, 4, 4, -1);
        chk("burst.cnt",  {16'b0, issued_cnt_o}, 32'd5);

        // Eight offers: FIFO fills after the 7th push, the 8th is dropped
        run_stream("full", 5, 8, 7, 7);
        chk("full.cnt",  {16'b0, issued_cnt_o}, 32'd12);
        chk("full.busy", {31'b0, busy_o}, 32'd0);

        // Push lands on the same edge as ACCESS -> IDLE
        drive(1'b1, word(7, 0));
        @(negedge clk);
        drive(1'b0, 32'h0);
        chk_apb("late.q", 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk_apb("late.setup0", 1'b1, 1'b0, word(7, 0));
        @(negedge clk);
        chk_apb("late.access0", 1'b1, 1'b1, word(7, 0));
        drive(1'b1, word(7, 1));
        @(negedge clk);
        drive(1'b0, 32'h0);
        chk_apb("late.idle", 1'b0, 1'b0, 32'h0);
        chk("late.busy", {31'b0, busy_o}, 32'd1);
        chk("late.cnt1", {16'b0, issued_cnt_o}, 32'd13);
        @(negedge clk);
        chk_apb("late.setup1", 1'b1, 1'b0, word(7, 1));
        @(negedge clk);
        chk_apb("late.access1", 1'b1, 1'b1, word(7, 1));
        @(negedge clk);
        chk_apb("late.done", 1'b0, 1'b0, 32'h0);
        chk("late.cnt2", {16'b0, issued_cnt_o}, 32'd14);

        // Reset during ACCESS with two commands still queued
        drive(1'b1, word(9, 0));
        @(negedge clk);
        drive(1'b1, word(9, 1));
        @(negedge clk);
        drive(1'b1, word(9, 2));
        @(negedge clk);
        drive(1'b0, 32'h0);
        chk_apb("abort.access", 1'b1, 1'b1, word(9, 0));
        #1 n_rst = 1'b0;
        #1;
        chk_apb("abort.now", 1'b0, 1'b0, 32'h0);
        chk("abort.busy",  {31'b0, busy_o},       32'd0);
        chk("abort.ready", {31'b0, cmd_ready_o},  32'd1);
        chk("abort.cnt",   {16'b0, issued_cnt_o}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk_apb($sformatf("abort.after[%0d]", i), 1'b0, 1'b0, 32'h0);
            chk($sformatf("abort.after_busy[%0d]", i), {31'b0, busy_o}, 32'd0);
            chk($sformatf("abort.after_cnt[%0d]", i), {16'b0, issued_cnt_o}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
